classifier_scheduler: RTL and testbench

Front-end sequencer for the digit classifier core. It accepts a 14x14 binary image as a stream of bytes from the host and assembles the 196-bit image register. It then pulses the classifier start, waits for the classifier's completion with a watchdog timeout, and returns the predicted digit over a valid/ready result handshake. It sits between the host byte interface and the classifier instance; it does not reset the classifier itself.

---
 rtl/classifier_scheduler.sv | 131 +++++++++++++
 tb/tb_classifier_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/classifier_scheduler.sv
// Front-end sequencer for the digit classifier: assembles a byte-streamed image,
// pulses the classifier start, watches for completion or timeout, returns the digit.
module classifier_scheduler #(
  parameter int IMG_BITS       = 196,
  parameter int TIMEOUT_CYCLES = 512,
  parameter int TO_W           = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic                cls_start,
  output logic [IMG_BITS-1:0] cls_image,
  input  logic [3:0]          cls_digit,
  input  logic                cls_valid,
  output logic [3:0]          res_digit,
  output logic                res_timeout,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                busy
);

  localparam int NUM_BYTES = (IMG_BITS + 7) / 8;
  localparam int IDX_W     = $clog2(NUM_BYTES);

  typedef enum logic [1:0] {S_LOAD, S_START, S_RUN, S_RESULT} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IMG_BITS-1:0] img_q, img_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                cls_valid_q;
  logic [3:0]          res_digit_q, res_digit_d;
  logic                res_timeout_q, res_timeout_d;
  logic                res_valid_q, res_valid_d;

  logic completion;
  logic timeout_hit;

  // Only a fresh rising edge counts; a level left over from the last inference does not.
  assign completion  = cls_valid & ~cls_valid_q;
  assign timeout_hit = (to_cnt_q + TO_W'(1)) == TO_W'(TIMEOUT_CYCLES - 1);

  // NOTE: the image register is an ordinary flop bank, so it is cleared in reset
  // like every other register; a half-loaded image must not survive a reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_LOAD;
      idx_q         <= '0;
      img_q         <= '0;
      to_cnt_q      <= '0;
      cls_valid_q   <= 1'b0;
      res_digit_q   <= 4'h0;
      res_timeout_q <= 1'b0;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      img_q         <= img_d;
      to_cnt_q      <= to_cnt_d;
      cls_valid_q   <= cls_valid;
      res_digit_q   <= res_digit_d;
      res_timeout_q <= res_timeout_d;
      res_valid_q   <= res_valid_d;
    end
  end

  // NOTE: every variable gets its hold value first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    img_d         = img_q;
    to_cnt_d      = to_cnt_q;
    res_digit_d   = res_digit_q;
    res_timeout_d = res_timeout_q;
    res_valid_d   = res_valid_q;

    case (state_q)
      S_LOAD: begin
        if (byte_valid) begin
          // Bits past IMG_BITS in the final byte simply have no destination.
          for (int i = 0; i < IMG_BITS; i++) begin
            if (idx_q == IDX_W'(i / 8)) img_d[i] = byte_in[i % 8];
          end
          if (idx_q == IDX_W'(NUM_BYTES - 1)) begin
            idx_d   = '0;
            state_d = S_START;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_START: begin
        to_cnt_d = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (completion) begin
          res_digit_d   = cls_digit;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          state_d       = S_RESULT;
        end else if (timeout_hit) begin
          res_digit_d   = 4'hF;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          state_d       = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign byte_ready  = (state_q == S_LOAD);
  assign cls_start   = (state_q == S_START);
  assign busy        = (state_q != S_LOAD);
  assign cls_image   = img_q;
  assign res_digit   = res_digit_q;
  assign res_timeout = res_timeout_q;
  assign res_valid   = res_valid_q;

endmodule

// File: tb/tb_classifier_scheduler.sv
// Directed bench for classifier_scheduler: reset, image assembly, completion,
// backpressure, timeout, completion/timeout tie and mid-operation reset.
module tb_classifier_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic         cls_start;
  logic [195:0] cls_image;
  logic [3:0]   cls_digit;
  logic         cls_valid;
  logic [3:0]   res_digit;
  logic         res_timeout;
  logic         res_valid;
  logic         res_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic [195:0] exp_img;

  classifier_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .cls_start  (cls_start),
    .cls_image  (cls_image),
    .cls_digit  (cls_digit),
    .cls_valid  (cls_valid),
    .res_digit  (res_digit),
    .res_timeout(res_timeout),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cls_start === 1'b1) start_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_byte_ready got %b exp 1", byte_ready);
    end
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    cls_digit = 4'h0; cls_valid = 1'b0; res_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL reset_byte_ready got %b exp 1", byte_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
    checks++; if (cls_start !== 1'b0) begin errors++; $display("FAIL reset_cls_start got %b exp 0", cls_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (cls_image !== 196'd0) begin errors++; $display("FAIL reset_cls_image got %h exp 0", cls_image); end
    checks++; if (res_digit !== 4'h0 || res_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_result got digit %h timeout %b exp 0 0", res_digit, res_timeout);
    end
  endtask

  // Stale classifier valid is high throughout the load, as after a prior inference.
  task automatic test_image_assembly();
    logic early_start;
    logic [7:0] b;
    early_start = 1'b0;
    cls_valid = 1'b1;
    cls_digit = 4'h2;
    exp_img = '0;
    for (int k = 0; k < 25; k++) begin
      b = (k == 24) ? 8'hFF : 8'(k);
      if (k < 24) exp_img[8*k +: 8] = b;
      else        exp_img[195:192] = b[3:0];
      send_byte(b);
      if (k < 24 && cls_start !== 1'b0) early_start = 1'b1;
    end
    checks++; if (early_start !== 1'b0) begin errors++; $display("FAIL load_early_start got %b exp 0", early_start); end
    checks++; if (cls_start !== 1'b1) begin errors++; $display("FAIL start_after_last got %b exp 1", cls_start); end
    checks++; if (cls_image[7:0] !== 8'h00 || cls_image[15:8] !== 8'h01) begin
      errors++; $display("FAIL img_low_bytes got %h %h exp 01 00", cls_image[15:8], cls_image[7:0]);
    end
    checks++; if (cls_image[191:184] !== 8'h17) begin errors++; $display("FAIL img_byte23 got %h exp 17", cls_image[191:184]); end
    checks++; if (cls_image[195:192] !== 4'hF) begin errors++; $display("FAIL img_top_nibble got %h exp f", cls_image[195:192]); end
    checks++; if (cls_image !== exp_img) begin errors++; $display("FAIL img_full got %h exp %h", cls_image, exp_img); end
    checks++; if (busy !== 1'b1 || byte_ready !== 1'b0) begin
      errors++; $display("FAIL start_flags got busy %b ready %b exp 1 0", busy, byte_ready);
    end
    tick();
    checks++; if (cls_start !== 1'b0) begin errors++; $display("FAIL start_one_cycle got %b exp 0", cls_start); end
  endtask

  // Entered in the first RUN cycle with the stale valid still high.
  task automatic test_normal_completion();
    logic early;
    early = 1'b0;
    tick();
    cls_valid = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stale_valid_ignored got %b exp 0", res_valid); end
    repeat (200) begin
      tick();
      if (res_valid !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL early_result got %b exp 0", early); end
    cls_digit = 4'h7;
    cls_valid = 1'b1;
    tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL done_res_valid got %b exp 1", res_valid); end
    checks++; if (res_digit !== 4'h7 || res_timeout !== 1'b0) begin
      errors++; $display("FAIL done_result got digit %h timeout %b exp 7 0", res_digit, res_timeout);
    end
  endtask

  task automatic test_backpressure();
    logic bad;
    bad = 1'b0;
    res_ready  = 1'b0;
    byte_in    = 8'hAA;
    byte_valid = 1'b1;
    repeat (10) begin
      tick();
      if (res_valid !== 1'b1 || res_digit !== 4'h7 || byte_ready !== 1'b0 ||
          busy !== 1'b1 || cls_image !== exp_img) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL backpressure_stable got %b exp 0", bad); end
    byte_valid = 1'b0;
    res_ready  = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || byte_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL handshake got valid %b ready %b busy %b exp 0 1 0", res_valid, byte_ready, busy);
    end
    checks++; if (res_digit !== 4'h7 || res_timeout !== 1'b0) begin
      errors++; $display("FAIL result_retained got digit %h timeout %b exp 7 0", res_digit, res_timeout);
    end
  endtask

  // The result is consumed in its first cycle because res_ready is already high.
  task automatic test_timeout();
    int count;
    for (int k = 0; k < 25; k++) send_byte(8'(3 * k + 1));
    checks++; if (cls_start !== 1'b1) begin errors++; $display("FAIL to_start got %b exp 1", cls_start); end
    res_ready = 1'b1;
    count = 0;
    tick(); count++;
    tick(); count++;
    cls_valid = 1'b0;
    while (res_valid !== 1'b1 && count < 1000) begin
      tick();
      count++;
    end
    checks++; if (count != 512) begin errors++; $display("FAIL timeout_latency got %0d exp 512", count); end
    checks++; if (res_digit !== 4'hF || res_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_result got digit %h timeout %b exp f 1", res_digit, res_timeout);
    end
    tick();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ready_on_entry got valid %b busy %b exp 0 0", res_valid, busy);
    end
  endtask

  // Completion arrives in the very cycle the watchdog expires.
  task automatic test_tie();
    logic early;
    early = 1'b0;
    for (int k = 0; k < 25; k++) send_byte(8'h5A);
    repeat (511) begin
      tick();
      if (res_valid !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL tie_early got %b exp 0", early); end
    cls_digit = 4'h3;
    cls_valid = 1'b1;
    tick();
    checks++; if (res_valid !== 1'b1 || res_digit !== 4'h3 || res_timeout !== 1'b0) begin
      errors++; $display("FAIL tie_result got valid %b digit %h timeout %b exp 1 3 0", res_valid, res_digit, res_timeout);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    cls_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    int s0;
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < 12; k++) send_byte(8'hFF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (cls_image !== 196'd0 || byte_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midload_reset got img %h ready %b busy %b exp 0 1 0", cls_image, byte_ready, busy);
    end
    s0 = start_cnt;
    for (int k = 0; k < 24; k++) send_byte(8'hC3);
    tick();
    checks++; if (start_cnt != s0 || busy !== 1'b0) begin
      errors++; $display("FAIL midload_no_start got starts %0d busy %b exp %0d 0", start_cnt, busy, s0);
    end
    send_byte(8'hC3);
    checks++; if (cls_start !== 1'b1) begin errors++; $display("FAIL fresh_start got %b exp 1", cls_start); end
    checks++; if (cls_image !== {4'h3, {24{8'hC3}}}) begin
      errors++; $display("FAIL fresh_image got %h exp %h", cls_image, {4'h3, {24{8'hC3}}});
    end
    repeat (20) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy got %b exp 1", busy); end
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || byte_ready !== 1'b1) begin
      errors++; $display("FAIL midrun_reset got busy %b valid %b ready %b exp 0 0 1", busy, res_valid, byte_ready);
    end
    s0 = start_cnt;
    repeat (600) begin
      tick();
      if (res_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0 || start_cnt != s0) begin
      errors++; $display("FAIL midrun_no_result got bad %b starts %0d exp 0 %0d", bad, start_cnt, s0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_image_assembly();
    test_normal_completion();
    test_backpressure();
    test_timeout();
    test_tie();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
